lut_stream_ram: RTL and testbench
=================================

Name: lut_stream_ram

Overview:
- Parametrised loadable lookup memory, DEPTH x DATA_W.
- Filled by a streaming byte loader with an auto-incrementing pointer, or by random-access writes.
- Read through a registered address port.
- Sits between the bidirectional IO load path and the output mux of a tile, replacing the single-purpose free-running loader. Adds flow control, full/wrap handling, a hardware clear sweep and synchronous read.

Parameters:
- DATA_W, 8, width of each entry.
- ADDR_W, 8, address width.
- DEPTH, 256, number of entries. Must satisfy 2 <= DEPTH <= 2**ADDR_W.
- WRAP, 0, streaming pointer behaviour at the last entry. 1 = wrap to 0 and keep accepting; 0 = stop and assert full.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- load_valid  in  1  stream byte present
- load_data  in  DATA_W  stream byte
- load_ready  out  1  stream byte accepted when load_valid && load_ready
- load_restart  in  1  pulse: pointer back to 0, full cleared
- wr_en  in  1  random write strobe
- wr_addr  in  ADDR_W  random write address
- wr_data  in  DATA_W  random write data
- clear_req  in  1  pulse: start zero-fill sweep
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  registered read data
- load_ptr  out  ADDR_W  next stream write location
- full  out  1  WRAP=0 only: all DEPTH entries streamed
- busy  out  1  clear sweep in progress

Behaviour:
- Reset (async assert, sync use): load_ptr=0, full=0, rd_data=0, internal sweep counter=0. FSM enters CLEAR, so busy=1 and load_ready=0.
- FSM states:
  - CLEAR: writes 0 to entry sweep_cnt each cycle. After writing entry DEPTH-1 → IDLE (DEPTH cycles total). On exit: load_ptr=0, full=0.
  - IDLE: normal operation. clear_req in IDLE → CLEAR next cycle, sweep_cnt=0.
  - clear_req during CLEAR restarts the sweep at 0.
  - Reset mid-sweep restarts it.
- load_ready = (state==IDLE) && !full && !wr_en && !load_restart.
- Stream accept: writes load_data to mem[load_ptr], then load_ptr+1.
  - At load_ptr==DEPTH-1 with WRAP=1: load_ptr→0, full stays 0.
  - At load_ptr==DEPTH-1 with WRAP=0: load_ptr stays DEPTH-1 and full→1 next cycle.
- Random write: in IDLE, wr_en writes wr_data to mem[wr_addr]; load_ptr is unaffected.
  - wr_addr >= DEPTH: write ignored.
  - wr_en during CLEAR: ignored.
- Priority, same cycle: clear sweep > load_restart > wr_en > stream accept.
  - load_restart sets load_ptr=0 and full=0 next cycle; no stream accept that cycle.
- Read: rd_data <= mem[rd_addr] every cycle (1-cycle latency).
  - rd_addr >= DEPTH or state==CLEAR: rd_data <= 0.
  - Read and write to the same address in the same cycle returns the OLD contents (read-first).
- Arithmetic: load_ptr is modulo DEPTH. No other arithmetic on data.

Optional Feature:
- Macro LUT_STREAM_CHECKSUM_EN.
- Defined: adds output load_csum [DATA_W].
  - Running XOR of every accepted stream byte.
  - Cleared to 0 on reset, load_restart and entry to CLEAR.
  - Updated the cycle after each accept.
  - Unaffected by random writes.
- Undefined: port absent, no checksum logic.

Test Plan:
- Reset → busy=1 for exactly DEPTH=256 cycles, then busy=0, load_ready=1. Every rd_addr 0..255 then reads 0x00.
- WRAP=0: stream 256 bytes with value=index^0xA5 → full=1, load_ready=0, load_ptr=255. rd_addr=0x10 gives 0xB5 one cycle later. A 257th byte is not accepted.
- WRAP=1: stream 258 bytes with values 0..255 then 0x77, 0x88 → full stays 0, load_ptr=2, mem[0]=0x77, mem[1]=0x88.
- Same cycle wr_en (addr 0x05, data 0x3C) and load_valid → load_ready=0, mem[5]=0x3C, load_ptr unchanged. A read of 0x05 in the write cycle returns the old value; the next read returns 0x3C.
- Stream 40 bytes, assert clear_req, then assert rst at sweep cycle 100 → sweep restarts. busy stays 1 for 256 more cycles after rst release, and all entries read 0.
- LUT_STREAM_CHECKSUM_EN: stream 0x12, 0x34, 0x56 → load_csum=0x70. A load_restart pulse → load_csum=0x00.

Source files
------------

// File: rtl/lut_stream_ram.sv
// Loadable DEPTH x DATA_W lookup memory: streaming loader, random writes, clear sweep, registered read.
// Optional running XOR of accepted stream bytes on load_csum when LUT_STREAM_CHECKSUM_EN is defined.
module lut_stream_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int WRAP   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              load_restart,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clear_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] load_ptr,
    output logic              full,
    output logic              busy
`ifdef LUT_STREAM_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] load_csum
`endif
);

    // state    | meaning
    // ST_CLEAR | zero-fill sweep, one entry per cycle; loader and random writes blocked
    // ST_IDLE  | normal operation: stream loads, random writes, reads
    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    logic [ADDR_W-1:0] sweep_cnt;
    logic              accept;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign busy       = (state == ST_CLEAR);
    assign load_ready = (state == ST_IDLE) && !full && !wr_en && !load_restart;
    assign accept     = load_valid && load_ready;

    // Single write port; sweep wins, and load_ready already excludes restart and random writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (state == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_cnt;
        end else if (load_restart) begin
            mem_we = 1'b0;
        end else if (wr_en) begin
            mem_we    = ({1'b0, wr_addr} < DEPTH_X);
            mem_waddr = wr_addr;
            mem_wdata = wr_data;
        end else if (accept) begin
            mem_we    = 1'b1;
            mem_waddr = load_ptr;
            mem_wdata = load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_CLEAR;
            sweep_cnt <= '0;
            load_ptr  <= '0;
            full      <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clear_req) begin
                        sweep_cnt <= '0;
                    end else if (sweep_cnt == LAST) begin
                        state     <= ST_IDLE;
                        sweep_cnt <= '0;
                        load_ptr  <= '0;
                        full      <= 1'b0;
                    end else begin
                        sweep_cnt <= sweep_cnt + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (clear_req) begin
                        state     <= ST_CLEAR;
                        sweep_cnt <= '0;
                    end else if (load_restart) begin
                        load_ptr <= '0;
                        full     <= 1'b0;
                    end else if (accept) begin
                        if (load_ptr == LAST) begin
                            if (WRAP != 0) load_ptr <= '0;
                            else           full     <= 1'b1;
                        end else begin
                            load_ptr <= load_ptr + ADDR_W'(1);
                        end
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Non-blocking read of mem gives read-first behaviour against a same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else if (state == ST_CLEAR || {1'b0, rd_addr} >= DEPTH_X)
            rd_data <= '0;
        else
            rd_data <= mem[rd_addr];
    end

`ifdef LUT_STREAM_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            load_csum <= '0;
        else if (state == ST_IDLE && (clear_req || load_restart))
            load_csum <= '0;
        else if (accept)
            load_csum <= load_csum ^ load_data;
    end
`endif

endmodule

// File: tb/tb_lut_stream_ram.sv
// Bench for lut_stream_ram: one WRAP=0 and one WRAP=1 instance on shared stimulus,
// read results checked by a queue-based scoreboard monitor.
module tb_lut_stream_ram;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = '0;
    logic       load_restart = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       clear_req = 1'b0;
    logic [7:0] rd_addr = '0;

    logic       ready0, ready1, full0, full1, busy0, busy1;
    logic [7:0] rd_data0, rd_data1, ptr0, ptr1;
`ifdef LUT_STREAM_CHECKSUM_EN
    logic [7:0] csum0, csum1;
`endif

    lut_stream_ram #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WRAP(0)) dut0 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ready0), .load_restart(load_restart), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .clear_req(clear_req),
        .rd_addr(rd_addr), .rd_data(rd_data0), .load_ptr(ptr0), .full(full0),
        .busy(busy0)
`ifdef LUT_STREAM_CHECKSUM_EN
        , .load_csum(csum0)
`endif
    );

    lut_stream_ram #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WRAP(1)) dut1 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ready1), .load_restart(load_restart), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .clear_req(clear_req),
        .rd_addr(rd_addr), .rd_data(rd_data1), .load_ptr(ptr1), .full(full1),
        .busy(busy1)
`ifdef LUT_STREAM_CHECKSUM_EN
        , .load_csum(csum1)
`endif
    );

    always #5 clk = ~clk;

    int compared = 0;
    int errors   = 0;

    typedef struct {
        string      nm;
        logic [7:0] e;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    logic rd_issue = 1'b0;
    logic rd_vld   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) rd_vld <= rd_issue;

    // Monitor: every issued read produces rd_data one cycle later.
    always @(negedge clk) begin
        if (rd_vld) begin
            if (q0.size() == 0 || q1.size() == 0) begin
                compared++;
                errors++;
                $display("FAIL scoreboard: read data with no expectation queued");
            end else begin
                exp_t a;
                exp_t b;
                a = q0.pop_front();
                b = q1.pop_front();
                chk({a.nm, "/w0"}, {24'd0, rd_data0}, {24'd0, a.e});
                chk({b.nm, "/w1"}, {24'd0, rd_data1}, {24'd0, b.e});
            end
        end
    end

    task automatic issue_rd(input string nm, input logic [7:0] a, input logic [7:0] e0,
                            input logic [7:0] e1);
        rd_addr  = a;
        rd_issue = 1'b1;
        q0.push_back('{nm, e0});
        q1.push_back('{nm, e1});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d);
        load_valid = 1'b1;
        load_data  = d;
        tick();
    endtask

    task automatic count_busy(input string nm);
        int n;
        n = 0;
        while (busy0 && n < 1000) begin
            n++;
            tick();
        end
        chk(nm, n, 256);
        chk({nm, "_w1busy"}, {31'd0, busy1}, 0);
    endtask

    task automatic read_all_zero(input string nm);
        for (int i = 0; i < 256; i++) begin
            issue_rd(nm, 8'(i), 8'h00, 8'h00);
            tick();
        end
        rd_issue = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        tick();
        chk("rst_busy", {31'd0, busy0}, 1);
        chk("rst_ready", {31'd0, ready0}, 0);
        chk("rst_ptr", {24'd0, ptr0}, 0);
        chk("rst_rd", {24'd0, rd_data0}, 0);
        rst = 1'b0;
        count_busy("init_busy_cycles");
        chk("init_ready0", {31'd0, ready0}, 1);
        chk("init_ready1", {31'd0, ready1}, 1);
        chk("init_full", {31'd0, full0}, 0);
        read_all_zero("init_zero");

        // Fill all 256 entries with index ^ 0xA5.
        for (int i = 0; i < 256; i++) send(8'(i) ^ 8'hA5);
        load_valid = 1'b0;
        #1;
        chk("fill_full0", {31'd0, full0}, 1);
        chk("fill_ready0", {31'd0, ready0}, 0);
        chk("fill_ptr0", {24'd0, ptr0}, 255);
        chk("fill_full1", {31'd0, full1}, 0);
        chk("fill_ptr1", {24'd0, ptr1}, 0);
        issue_rd("rd_0x10", 8'h10, 8'hB5, 8'hB5);
        tick();
        rd_issue = 1'b0;

        // Bytes 257/258: rejected by the stopping instance, wrapped into 0/1 by the other.
        send(8'h77);
        send(8'h88);
        load_valid = 1'b0;
        chk("ovf_ptr0", {24'd0, ptr0}, 255);
        chk("ovf_full0", {31'd0, full0}, 1);
        chk("wrap_ptr1", {24'd0, ptr1}, 2);
        chk("wrap_full1", {31'd0, full1}, 0);
        issue_rd("rd_0", 8'h00, 8'hA5, 8'h77);
        tick();
        issue_rd("rd_1", 8'h01, 8'hA4, 8'h88);
        tick();
        issue_rd("rd_ff", 8'hFF, 8'h5A, 8'h5A);
        tick();
        rd_issue = 1'b0;

        load_restart = 1'b1;
        #1;
        chk("restart_ready", {31'd0, ready0}, 0);
        tick();
        load_restart = 1'b0;
        #1;
        chk("restart_ptr0", {24'd0, ptr0}, 0);
        chk("restart_full0", {31'd0, full0}, 0);
        chk("restart_ready0", {31'd0, ready0}, 1);
        chk("restart_ptr1", {24'd0, ptr1}, 0);
        tick();

        // Random write collides with a stream byte and a read of the same address.
        wr_en      = 1'b1;
        wr_addr    = 8'h05;
        wr_data    = 8'h3C;
        load_valid = 1'b1;
        load_data  = 8'hEE;
        issue_rd("rd_old5", 8'h05, 8'hA0, 8'hA0);
        #1;
        chk("wr_blocks_ready", {31'd0, ready0}, 0);
        tick();
        wr_en      = 1'b0;
        load_valid = 1'b0;
        issue_rd("rd_new5", 8'h05, 8'h3C, 8'h3C);
        tick();
        rd_issue = 1'b0;
        chk("wr_ptr_unchanged", {24'd0, ptr0}, 0);

        send(8'h12);
        send(8'h34);
        send(8'h56);
        load_valid = 1'b0;
        chk("three_ptr", {24'd0, ptr0}, 3);
        issue_rd("rd_s0", 8'h00, 8'h12, 8'h12);
        tick();
        issue_rd("rd_s2", 8'h02, 8'h56, 8'h56);
        tick();
        rd_issue = 1'b0;
`ifdef LUT_STREAM_CHECKSUM_EN
        chk("csum_three", {24'd0, csum0}, 32'h70);
        chk("csum_three_w1", {24'd0, csum1}, 32'h70);
        wr_en   = 1'b1;
        wr_addr = 8'h09;
        wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        tick();
        chk("csum_wr_ignored", {24'd0, csum0}, 32'h70);
        load_restart = 1'b1;
        tick();
        load_restart = 1'b0;
        tick();
        chk("csum_restart", {24'd0, csum0}, 0);
`endif

        load_restart = 1'b1;
        tick();
        load_restart = 1'b0;
        for (int i = 0; i < 40; i++) send(8'(i + 1));
        load_valid = 1'b0;
        chk("forty_ptr", {24'd0, ptr0}, 40);

        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("clear_busy", {31'd0, busy0}, 1);
        issue_rd("rd_during_clear", 8'h01, 8'h00, 8'h00);
        tick();
        rd_issue = 1'b0;
        repeat (98) tick();
        chk("clear_ptr_held", {24'd0, ptr0}, 40);
        rst = 1'b1;
        tick();
        tick();
        chk("midrst_busy", {31'd0, busy0}, 1);
        chk("midrst_ptr", {24'd0, ptr0}, 0);
        rst = 1'b0;
        count_busy("resweep_cycles");
        chk("resweep_ready", {31'd0, ready0}, 1);
        read_all_zero("resweep_zero");

        tick();
        chk("sb_drained", q0.size() + q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
        $finish;
    end

endmodule
